// File: rtl/pong_renderer.sv
// pong_renderer: VGA scan-out stage for the pong game.
//
// Generates 640x480@60 timing from a free-running pixel counter pair,
// snapshots the game state once per frame (tear-free) and paints ball,
// paddles, score digits and centre net. Every output is registered one
// cycle after the counter state it describes.
//
// Ports:
//   clk                  pixel clock, one pixel per cycle
//   rst_n                asynchronous active-low reset
//   ball_x, ball_y       ball top-left position
//   l_paddle_y           left paddle top edge
//   r_paddle_y           right paddle top edge
//   score_l, score_r     scores (0-9 drawn, 10-15 blank)
//   hsync, vsync         active-low syncs
//   rgb                  {R,G,B}, zero outside the active area
//   frame_tick           one-cycle pulse per frame, at the first blanking line
module pong_renderer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned PADDLE_X  = 20,
  parameter int unsigned PADDLE_W  = 10,
  parameter int unsigned PADDLE_H  = 60,
  parameter int unsigned BALL_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] l_paddle_y,
  input  logic [9:0] r_paddle_y,
  input  logic [3:0] score_l,
  input  logic [3:0] score_r,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
  localparam logic [9:0] HS_LO = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_LO = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Geometry at 11 bits so position + size never wraps.
  localparam logic [10:0] BALL_W = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_W  = 11'(PADDLE_W);
  localparam logic [10:0] PAD_H  = 11'(PADDLE_H);
  localparam logic [10:0] LP_X   = 11'(PADDLE_X);
  localparam logic [10:0] RP_X   = 11'(H_ACTIVE - PADDLE_X - PADDLE_W);
  localparam logic [10:0] NET_X0 = 11'(H_ACTIVE / 2 - 2);
  localparam logic [10:0] NET_X1 = 11'(H_ACTIVE / 2 + 2);
  localparam logic [10:0] DL_X   = 11'(H_ACTIVE / 2 - 64);
  localparam logic [10:0] DR_X   = 11'(H_ACTIVE / 2 + 40);
  localparam logic [10:0] DIG_W  = 11'd24;
  localparam logic [10:0] DIG_Y0 = 11'd16;
  localparam logic [10:0] DIG_Y1 = 11'd56;

  // Shadow reset values: ball centred, paddles vertically centred.
  localparam logic [9:0] BALL_X0 = 10'(H_ACTIVE / 2);
  localparam logic [9:0] BALL_Y0 = 10'(V_ACTIVE / 2);
  localparam logic [9:0] PAD_Y0  = 10'((V_ACTIVE - PADDLE_H) / 2);

  logic [9:0] h_cnt, v_cnt;
  logic [9:0] sh_bx, sh_by, sh_lp, sh_rp;
  logic [3:0] sh_sl, sh_sr;

  // Stage 0: pixel / line counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Latched on the last pixel of the frame so the whole next frame
  // renders from one consistent game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_bx <= BALL_X0;
      sh_by <= BALL_Y0;
      sh_lp <= PAD_Y0;
      sh_rp <= PAD_Y0;
      sh_sl <= '0;
      sh_sr <= '0;
    end else if (h_cnt == H_MAX && v_cnt == V_MAX) begin
      sh_bx <= ball_x;
      sh_by <= ball_y;
      sh_lp <= l_paddle_y;
      sh_rp <= r_paddle_y;
      sh_sl <= score_l;
      sh_sr <= score_r;
    end
  end

  // 3x5 glyphs, row 0 in the top three bits, column 0 is the MSB of a row.
  function automatic logic [14:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b010_110_010_010_111;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      default: glyph = '0;
    endcase
  endfunction

  function automatic logic font_px(input logic [3:0] d, input logic [2:0] row,
                                   input logic [1:0] col);
    logic [14:0] g;
    logic [2:0]  bits;
    g = glyph(d);
    case (row)
      3'd0:    bits = g[14:12];
      3'd1:    bits = g[11:9];
      3'd2:    bits = g[8:6];
      3'd3:    bits = g[5:3];
      3'd4:    bits = g[2:0];
      default: bits = '0;
    endcase
    case (col)
      2'd0:    font_px = bits[2];
      2'd1:    font_px = bits[1];
      2'd2:    font_px = bits[0];
      default: font_px = 1'b0;
    endcase
  endfunction

  logic [10:0] x, y;
  logic        active, ball_hit, lp_hit, rp_hit, net_hit;
  logic        in_dl, in_dr, dig_l, dig_r;
  logic [1:0]  col_l, col_r;
  logic [2:0]  row_d;
  logic [2:0]  colour;

  always_comb begin
    x      = {1'b0, h_cnt};
    y      = {1'b0, v_cnt};
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    ball_hit = (x >= {1'b0, sh_bx}) && (x < {1'b0, sh_bx} + BALL_W) &&
               (y >= {1'b0, sh_by}) && (y < {1'b0, sh_by} + BALL_W);
    lp_hit   = (x >= LP_X) && (x < LP_X + PAD_W) &&
               (y >= {1'b0, sh_lp}) && (y < {1'b0, sh_lp} + PAD_H);
    rp_hit   = (x >= RP_X) && (x < RP_X + PAD_W) &&
               (y >= {1'b0, sh_rp}) && (y < {1'b0, sh_rp} + PAD_H);
    net_hit  = (x >= NET_X0) && (x < NET_X1) && !v_cnt[4];

    // Font is scaled by 8, so column/row are the offsets shifted right by 3.
    in_dl = (x >= DL_X) && (x < DL_X + DIG_W) && (y >= DIG_Y0) && (y < DIG_Y1);
    in_dr = (x >= DR_X) && (x < DR_X + DIG_W) && (y >= DIG_Y0) && (y < DIG_Y1);
    col_l = 2'((x - DL_X) >> 3);
    col_r = 2'((x - DR_X) >> 3);
    row_d = 3'((y - DIG_Y0) >> 3);
    dig_l = in_dl && font_px(sh_sl, row_d, col_l);
    dig_r = in_dr && font_px(sh_sr, row_d, col_r);

    colour = 3'b000;
    if (!active)            colour = 3'b000;
    else if (ball_hit)      colour = 3'b111;
    else if (lp_hit)        colour = 3'b011;
    else if (rp_hit)        colour = 3'b101;
    else if (dig_l || dig_r) colour = 3'b111;
    else if (net_hit)       colour = 3'b001;
  end

  // Stage 1: all outputs registered together so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= '0;
      frame_tick <= 1'b0;
    end else begin
      hsync      <= !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
      vsync      <= !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
      rgb        <= colour;
      frame_tick <= (h_cnt == '0) && (v_cnt == V_ACT);
    end
  end

endmodule

// File: tb/tb_pong_renderer.sv
// Scoreboard bench for pong_renderer. Full horizontal timing, shortened
// vertical timing (64 active lines) so three frames stay short. Expected
// pixels and tick times are queued by the stimulus; a monitor tracks the
// output cycle count since reset release and compares as outputs appear.
module tb_pong_renderer;

  localparam int unsigned HT    = 800;
  localparam int unsigned VA    = 64;
  localparam int unsigned VF    = 2;
  localparam int unsigned VS    = 2;
  localparam int unsigned VB    = 4;
  localparam int unsigned VT    = VA + VF + VS + VB;
  localparam int unsigned FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ball_x, ball_y, l_paddle_y, r_paddle_y;
  logic [3:0] score_l, score_r;
  logic       hsync, vsync, frame_tick;
  logic [2:0] rgb;

  pong_renderer #(
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ball_x(ball_x), .ball_y(ball_y),
    .l_paddle_y(l_paddle_y), .r_paddle_y(r_paddle_y),
    .score_l(score_l), .score_r(score_r),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Edges counted since reset release; after edge n the outputs show
  // counter state n-1.
  int unsigned cyc = 0;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned at;
    logic [2:0]  rgb;
    string       name;
  } px_t;

  px_t         px_q[$];
  int unsigned tick_q[$];
  bit          mon_en = 1'b1;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic expect_px(input int unsigned f, input int unsigned x,
                           input int unsigned y, input logic [2:0] c,
                           input string nm);
    px_t e;
    int  i;
    e.at   = f * FRAME + y * HT + x + 1;
    e.rgb  = c;
    e.name = $sformatf("%s(f%0d,x%0d,y%0d)", nm, f, x, y);
    i = 0;
    while (i < px_q.size() && px_q[i].at <= e.at) i++;
    px_q.insert(i, e);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor state
  logic        hs_p = 1'b1, vs_p = 1'b1;
  int unsigned hs_fall = 0, vs_fall = 0, n_hfall = 0, n_vfall = 0, n_tick = 0;

  initial begin
    px_t         e;
    int unsigned t;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        while (px_q.size() > 0 && px_q[0].at <= cyc) begin
          e = px_q.pop_front();
          checks++;
          if (e.at != cyc || rgb !== e.rgb) begin
            errors++;
            $display("FAIL %s: rgb=%0d at cycle %0d, expected %0d at cycle %0d",
                     e.name, rgb, cyc, e.rgb, e.at);
          end
        end
        if (hs_p && !hsync) begin
          check(n_hfall == 0 ? "hsync_first_fall" : "hsync_period",
                int'(cyc), int'(n_hfall == 0 ? 657 : hs_fall + HT));
          hs_fall = cyc;
          n_hfall++;
        end
        if (!hs_p && hsync) check("hsync_width", int'(cyc - hs_fall), 96);
        hs_p = hsync;
        if (vs_p && !vsync) begin
          check(n_vfall == 0 ? "vsync_first_fall" : "vsync_period",
                int'(cyc), int'(n_vfall == 0 ? (VA + VF) * HT + 1 : vs_fall + FRAME));
          vs_fall = cyc;
          n_vfall++;
        end
        if (!vs_p && vsync) check("vsync_width", int'(cyc - vs_fall), 2 * HT);
        vs_p = vsync;
        if (frame_tick) begin
          n_tick++;
          t = (tick_q.size() > 0) ? tick_q.pop_front() : 0;
          check("frame_tick_cycle", int'(cyc), int'(t));
        end
      end
    end
  end

  initial begin
    ball_x = 10'd320; ball_y = 10'd32; l_paddle_y = 10'd2; r_paddle_y = 10'd2;
    score_l = 4'd0; score_r = 4'd0;

    for (int unsigned f = 0; f < 3; f++) tick_q.push_back(f * FRAME + VA * HT + 1);

    // Frame 0: reset shadows (ball 320,32; paddles at 2; scores 0)
    expect_px(0, 320, 32, 3'b111, "f0_ball_tl");
    expect_px(0, 327, 39, 3'b111, "f0_ball_br");
    expect_px(0, 328, 32, 3'b000, "f0_ball_right_edge");
    expect_px(0, 319, 32, 3'b001, "f0_net");
    expect_px(0, 320, 40, 3'b001, "f0_net_below_ball");
    expect_px(0, 320, 31, 3'b000, "f0_net_gap");
    expect_px(0, 20, 2, 3'b011, "f0_lpad_top");
    expect_px(0, 29, 61, 3'b011, "f0_lpad_bottom");
    expect_px(0, 20, 62, 3'b000, "f0_lpad_past");
    expect_px(0, 20, 1, 3'b000, "f0_lpad_above");
    expect_px(0, 610, 2, 3'b101, "f0_rpad");
    expect_px(0, 620, 2, 3'b000, "f0_rpad_right_edge");
    expect_px(0, 256, 16, 3'b111, "f0_digit0_r0c0");
    expect_px(0, 264, 16, 3'b111, "f0_digit0_r0c1");
    expect_px(0, 264, 24, 3'b000, "f0_digit0_r1c1");

    // Frame 1: ball (24,10), lp 0, rp 30, scores 1 and 8
    expect_px(1, 320, 32, 3'b001, "f1_old_ball_gone");
    expect_px(1, 24, 10, 3'b111, "f1_overlap");
    expect_px(1, 30, 10, 3'b111, "f1_ball_past_paddle");
    expect_px(1, 31, 17, 3'b111, "f1_ball_br");
    expect_px(1, 32, 10, 3'b000, "f1_ball_edge");
    expect_px(1, 20, 10, 3'b011, "f1_paddle_only");
    expect_px(1, 24, 18, 3'b011, "f1_paddle_below_ball");
    expect_px(1, 23, 9, 3'b011, "f1_paddle_above_ball");
    expect_px(1, 20, 0, 3'b011, "f1_lpad_top");
    expect_px(1, 29, 59, 3'b011, "f1_lpad_bottom");
    expect_px(1, 20, 60, 3'b000, "f1_lpad_past");
    expect_px(1, 610, 30, 3'b101, "f1_rpad");
    expect_px(1, 609, 30, 3'b000, "f1_rpad_left_edge");
    expect_px(1, 610, 29, 3'b000, "f1_rpad_above");
    expect_px(1, 619, 63, 3'b101, "f1_rpad_clip_row");
    expect_px(1, 256, 16, 3'b000, "f1_one_r0c0");
    expect_px(1, 264, 16, 3'b111, "f1_one_r0c1");
    expect_px(1, 256, 24, 3'b111, "f1_one_r1c0");
    expect_px(1, 272, 40, 3'b000, "f1_one_r3c2");
    expect_px(1, 272, 48, 3'b111, "f1_one_r4c2");
    expect_px(1, 279, 55, 3'b111, "f1_one_last_px");
    expect_px(1, 280, 55, 3'b000, "f1_one_box_right");
    expect_px(1, 255, 48, 3'b000, "f1_one_box_left");
    expect_px(1, 360, 16, 3'b111, "f1_eight_r0c0");
    expect_px(1, 360, 15, 3'b000, "f1_eight_box_top");
    expect_px(1, 368, 24, 3'b000, "f1_eight_r1c1");
    expect_px(1, 368, 32, 3'b111, "f1_eight_r2c1");
    expect_px(1, 368, 40, 3'b000, "f1_eight_r3c1");
    expect_px(1, 383, 55, 3'b111, "f1_eight_last_px");
    expect_px(1, 384, 55, 3'b000, "f1_eight_box_right");
    expect_px(1, 360, 56, 3'b000, "f1_eight_box_bottom");
    expect_px(1, 318, 0, 3'b001, "f1_net_left");
    expect_px(1, 321, 15, 3'b001, "f1_net_right");
    expect_px(1, 317, 0, 3'b000, "f1_net_before");
    expect_px(1, 322, 0, 3'b000, "f1_net_after");
    expect_px(1, 318, 16, 3'b000, "f1_net_gap");

    // Frame 2: ball at right edge (636,40), score_l 12 blank
    expect_px(2, 0, 40, 3'b000, "f2_no_wrap_x0");
    expect_px(2, 3, 47, 3'b000, "f2_no_wrap_x3");
    expect_px(2, 635, 40, 3'b000, "f2_before_ball");
    expect_px(2, 636, 40, 3'b111, "f2_ball_clip_tl");
    expect_px(2, 639, 47, 3'b111, "f2_ball_clip_last");
    expect_px(2, 640, 40, 3'b000, "f2_blank_640");
    expect_px(2, 700, 40, 3'b000, "f2_blank_700");
    expect_px(2, 636, 48, 3'b000, "f2_ball_below");
    expect_px(2, 256, 16, 3'b000, "f2_blank_digit_r0c0");
    expect_px(2, 264, 16, 3'b000, "f2_blank_digit_r0c1");
    expect_px(2, 256, 24, 3'b000, "f2_blank_digit_r1c0");
    expect_px(2, 272, 48, 3'b000, "f2_blank_digit_r4c2");
    expect_px(2, 360, 16, 3'b111, "f2_eight_r0c0");
    expect_px(2, 368, 24, 3'b000, "f2_eight_r1c1");

    // Reset held with the clock running
    repeat (3) @(negedge clk);
    check("reset_hsync", int'(hsync), 1);
    check("reset_vsync", int'(vsync), 1);
    check("reset_rgb", int'(rgb), 0);
    check("reset_frame_tick", int'(frame_tick), 0);

    @(negedge clk);
    rst_n = 1'b1;

    wait_cyc(10 * HT);
    ball_x = 10'd24; ball_y = 10'd10; l_paddle_y = 10'd0; r_paddle_y = 10'd30;
    score_l = 4'd1; score_r = 4'd8;

    wait_cyc(FRAME + 10 * HT);
    ball_x = 10'd636; ball_y = 10'd40; score_l = 4'd12;

    // Mid-line, inside the hsync pulse of the line after the third tick
    wait_cyc(2 * FRAME + VA * HT + 700);
    check("pixel_queue_drained", px_q.size(), 0);
    check("tick_queue_drained", tick_q.size(), 0);
    check("tick_count", int'(n_tick), 3);
    check("hsync_before_async_reset", int'(hsync), 0);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_hsync", int'(hsync), 1);
    check("async_reset_vsync", int'(vsync), 1);
    check("async_reset_rgb", int'(rgb), 0);
    check("async_reset_frame_tick", int'(frame_tick), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
